// File: rtl/apb_master_pkg.sv
// State encoding and constants for the command-to-APB master.
package apb_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_t;

   localparam logic [1:0] ALIGN_MASK = 2'b11;
   localparam int         TMO_CNT_W  = 16;

   function automatic logic is_misaligned(input logic [1:0] addr_lsb);
      return |(addr_lsb & ALIGN_MASK);
   endfunction

endpackage

// File: rtl/apb_pkg.sv
// Shared APB protocol types.
package apb_pkg;

   typedef logic [2:0] prot_t;

   localparam prot_t PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb_master_tmo.sv
// ACCESS-phase wait counter; expire flags the last allowed wait cycle.
module apb_master_tmo
   import apb_master_pkg::*;
(
   input  logic                 p_clk,
   input  logic                 p_rst,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [TMO_CNT_W-1:0] limit,
   output logic                 expire
);

   logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + TMO_CNT_W'(1);
      end
   end

   always_ff @(posedge p_clk) begin
      if (p_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A zero limit never expires.
   assign expire = enable && (limit != '0) && (cnt_q == limit - TMO_CNT_W'(1));

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding command interface to APB master bridge.
//  state  | meaning
//  IDLE   | ready for a command
//  SETUP  | APB setup phase, psel only
//  ACCESS | psel+penable, waiting for pready or timeout
//  RESP   | response held until rsp_ready
module apb_cmd_master
   import apb_master_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        p_clk,
   input  logic                        p_rst,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic                        cmd_write,
   input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [APB_DATA_WIDTH/8-1:0] cmd_strb,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [APB_DATA_WIDTH-1:0]   rsp_rdata,
   output logic                        rsp_slverr,
   output logic [APB_ADDR_WIDTH-1:0]   apb_paddr,
   output apb_pkg::prot_t              apb_pprot,
   output logic                        apb_psel,
   output logic                        apb_penable,
   output logic                        apb_pwrite,
   output logic [APB_DATA_WIDTH-1:0]   apb_pwdata,
   output logic [APB_DATA_WIDTH/8-1:0] apb_pstrb,
   input  logic                        apb_pready,
   input  logic [APB_DATA_WIDTH-1:0]   apb_prdata,
   input  logic                        apb_pslverr
);

   localparam int STRB_W = APB_DATA_WIDTH / 8;
   localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);

   state_t                    state_q, state_d;
   logic                      cmd_ready_q, cmd_ready_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                      pwrite_q, pwrite_d;
   logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [STRB_W-1:0]         pstrb_q, pstrb_d;
   logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                      slverr_q, slverr_d;
   logic                      tmo_expire;

   apb_master_tmo u_tmo (
      .p_clk  (p_clk),
      .p_rst  (p_rst),
      .clear  (state_q == ST_SETUP),
      .enable ((state_q == ST_ACCESS) && !apb_pready),
      .limit  (TMO_LIMIT),
      .expire (tmo_expire)
   );

   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      pstrb_d  = pstrb_q;
      rdata_d  = rdata_q;
      slverr_d = slverr_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               paddr_d  = cmd_addr;
               pwrite_d = cmd_write;
               pwdata_d = cmd_write ? cmd_wdata : '0;
               pstrb_d  = cmd_write ? cmd_strb : '0;
               if (is_misaligned(cmd_addr[1:0])) begin
                  rdata_d  = '0;
                  slverr_d = 1'b1;
                  state_d  = ST_RESP;
               end else begin
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // pready takes priority over a timeout in the same cycle
            if (apb_pready) begin
               rdata_d  = (pwrite_q || apb_pslverr) ? '0 : apb_prdata;
               slverr_d = apb_pslverr;
               state_d  = ST_RESP;
            end else if (tmo_expire) begin
               rdata_d  = '0;
               slverr_d = 1'b1;
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      cmd_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge p_clk) begin
      if (p_rst) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rdata_q     <= '0;
         slverr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         rdata_q     <= rdata_d;
         slverr_q    <= slverr_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = (state_q == ST_RESP);
   assign rsp_rdata   = rdata_q;
   assign rsp_slverr  = slverr_q;
   assign apb_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign apb_penable = (state_q == ST_ACCESS);
   assign apb_paddr   = paddr_q;
   assign apb_pwrite  = pwrite_q;
   assign apb_pwdata  = pwdata_q;
   assign apb_pstrb   = pstrb_q;
   assign apb_pprot   = apb_pkg::PROT_DEFAULT;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Table-driven bench for apb_cmd_master with a response scoreboard and APB slave model.
module tb_apb_cmd_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          p_clk = 1'b0;
   logic          p_rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic          cmd_write;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_slverr;
   logic [AW-1:0] apb_paddr;
   apb_pkg::prot_t apb_pprot;
   logic          apb_psel;
   logic          apb_penable;
   logic          apb_pwrite;
   logic [DW-1:0] apb_pwdata;
   logic [SW-1:0] apb_pstrb;
   logic          apb_pready;
   logic [DW-1:0] apb_prdata;
   logic          apb_pslverr;

   apb_cmd_master #(
      .APB_ADDR_WIDTH (AW),
      .APB_DATA_WIDTH (DW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .p_clk       (p_clk),
      .p_rst       (p_rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_write   (cmd_write),
      .cmd_wdata   (cmd_wdata),
      .cmd_strb    (cmd_strb),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_slverr  (rsp_slverr),
      .apb_paddr   (apb_paddr),
      .apb_pprot   (apb_pprot),
      .apb_psel    (apb_psel),
      .apb_penable (apb_penable),
      .apb_pwrite  (apb_pwrite),
      .apb_pwdata  (apb_pwdata),
      .apb_pstrb   (apb_pstrb),
      .apb_pready  (apb_pready),
      .apb_prdata  (apb_prdata),
      .apb_pslverr (apb_pslverr)
   );

   always #5 p_clk = ~p_clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic          write;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
      int            wait_n;    // ACCESS cycles before pready; -1 = never
      logic [DW-1:0] prdata;
      logic          pslverr;
      int            hold;      // extra cycles rsp_ready stays low
      logic [DW-1:0] exp_rdata;
      logic          exp_slverr;
      int            exp_lat;   // cycles from accept to rsp_valid
   } vec_t;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          slverr;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   lat_psel = -1;
      int   lat_pen  = -1;
      int   lat_rsp  = -1;
      int   psel_cyc = 0;
      int   acc      = 0;
      int   guard    = 0;
      logic stable_ok = 1'b1;
      logic mis;
      logic [DW-1:0] exp_pwdata;
      logic [SW-1:0] exp_pstrb;
      logic [DW-1:0] held_rdata;
      logic          held_slverr;
      rsp_t e;

      mis        = (v.addr[1:0] != 2'b00);
      exp_pwdata = v.write ? v.wdata : '0;
      exp_pstrb  = v.write ? v.strb : '0;
      exp_q.push_back('{v.exp_rdata, v.exp_slverr});

      @(negedge p_clk);
      while (!cmd_ready && guard < 20) begin
         @(negedge p_clk);
         guard++;
      end
      check($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_addr  = v.addr;
      cmd_write = v.write;
      cmd_wdata = v.wdata;
      cmd_strb  = v.strb;
      @(posedge p_clk);

      for (int k = 1; k <= 40 && lat_rsp < 0; k++) begin
         @(negedge p_clk);
         if (k == 1) begin
            cmd_valid = 1'b0;
            cmd_addr  = 32'hFFFF_FFFC;
            cmd_write = ~v.write;
            cmd_wdata = ~v.wdata;
            cmd_strb  = ~v.strb;
         end
         if (apb_psel) begin
            psel_cyc++;
            if (lat_psel < 0) lat_psel = k;
            if (apb_paddr !== v.addr || apb_pwrite !== v.write ||
                apb_pwdata !== exp_pwdata || apb_pstrb !== exp_pstrb)
               stable_ok = 1'b0;
         end
         if (apb_penable && lat_pen < 0) lat_pen = k;
         if (apb_psel && apb_penable) begin
            apb_pready  = (v.wait_n >= 0) && (acc == v.wait_n);
            apb_prdata  = apb_pready ? v.prdata : $urandom;
            apb_pslverr = apb_pready ? v.pslverr : 1'b0;
            acc++;
         end else begin
            apb_pready  = 1'b0;
            apb_pslverr = 1'b0;
         end
         if (rsp_valid) lat_rsp = k;
      end
      apb_pready = 1'b0;

      check($sformatf("v%0d_rsp_latency", idx), lat_rsp, v.exp_lat);
      check($sformatf("v%0d_psel_first", idx), lat_psel, mis ? -1 : 1);
      check($sformatf("v%0d_penable_first", idx), lat_pen, mis ? -1 : 2);
      check($sformatf("v%0d_psel_cycles", idx), psel_cyc, mis ? 0 : v.exp_lat - 1);
      check($sformatf("v%0d_addr_phase_stable", idx), stable_ok, 1);
      check($sformatf("v%0d_psel_at_rsp", idx), apb_psel, 0);

      e = exp_q.pop_front();
      check($sformatf("v%0d_rdata", idx), rsp_rdata, e.rdata);
      check($sformatf("v%0d_slverr", idx), rsp_slverr, e.slverr);
      if (lat_rsp < 0) return;

      held_rdata  = rsp_rdata;
      held_slverr = rsp_slverr;
      for (int h = 0; h < v.hold; h++) begin
         @(negedge p_clk);
         check($sformatf("v%0d_hold%0d_valid", idx, h), rsp_valid, 1);
         check($sformatf("v%0d_hold%0d_rsp", idx, h), {rsp_rdata, rsp_slverr},
               {held_rdata, held_slverr});
         check($sformatf("v%0d_hold%0d_cmd_ready", idx, h), cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge p_clk);
      @(negedge p_clk);
      rsp_ready = 1'b0;
      check($sformatf("v%0d_rsp_done", idx), rsp_valid, 0);
      check($sformatf("v%0d_ready_after", idx), cmd_ready, 1);
   endtask

   vec_t vecs[9];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rsp_seen;
      int psel_seen;

      //              addr          wr    wdata          strb  wait  prdata         perr hold exp_rdata      exp_err lat
      vecs[0] = '{32'h0013_0004, 1'b1, 32'h0003_3333, 4'hF,  0, 32'h0,         1'b0, 0, 32'h0,         1'b0,  3};
      vecs[1] = '{32'h0013_0000, 1'b0, 32'h0,         4'hF,  3, 32'hA5A5_1234, 1'b0, 0, 32'hA5A5_1234, 1'b0,  6};
      vecs[2] = '{32'h0013_0010, 1'b0, 32'h0,         4'h0, -1, 32'h0,         1'b0, 0, 32'h0,         1'b1, 10};
      vecs[3] = '{32'h0013_0002, 1'b1, 32'h1111_2222, 4'hF,  0, 32'h0,         1'b0, 0, 32'h0,         1'b1,  1};
      vecs[4] = '{32'h0013_0020, 1'b0, 32'h0,         4'h0,  0, 32'hDEAD_BEEF, 1'b1, 0, 32'h0,         1'b1,  3};
      vecs[5] = '{32'h0013_0024, 1'b0, 32'h0,         4'h0,  1, 32'h1234_5678, 1'b0, 5, 32'h1234_5678, 1'b0,  4};
      vecs[6] = '{32'h0013_0028, 1'b0, 32'h0,         4'h0,  7, 32'h0BAD_F00D, 1'b0, 0, 32'h0BAD_F00D, 1'b0, 10};
      vecs[7] = '{32'h0013_002C, 1'b1, 32'hCAFE_0001, 4'h5,  1, 32'h5555_5555, 1'b1, 2, 32'h0,         1'b1,  4};
      vecs[8] = '{32'h0013_0033, 1'b0, 32'h0,         4'h0,  0, 32'h0,         1'b0, 0, 32'h0,         1'b1,  1};

      p_rst       = 1'b1;
      cmd_valid   = 1'b0;
      cmd_addr    = '0;
      cmd_write   = 1'b0;
      cmd_wdata   = '0;
      cmd_strb    = '0;
      rsp_ready   = 1'b0;
      apb_pready  = 1'b0;
      apb_prdata  = '0;
      apb_pslverr = 1'b0;

      repeat (3) @(posedge p_clk);
      @(negedge p_clk);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_psel_penable", {apb_psel, apb_penable}, 0);
      check("rst_addr_phase", {apb_paddr, apb_pwrite, apb_pstrb}, 0);
      check("rst_pwdata", apb_pwdata, 0);
      check("rst_rsp_fields", {rsp_rdata, rsp_slverr}, 0);
      check("rst_pprot", apb_pprot, 0);
      p_rst = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // reset while the slave is stalling in ACCESS
      exp_q.push_back('{32'h0, 1'b1});
      @(negedge p_clk);
      check("mid_rst_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_addr  = 32'h0013_0040;
      cmd_write = 1'b0;
      @(posedge p_clk);
      @(negedge p_clk);
      cmd_valid = 1'b0;
      @(negedge p_clk);
      check("mid_rst_in_access", {apb_psel, apb_penable}, 2'b11);
      p_rst = 1'b1;
      @(posedge p_clk);
      @(negedge p_clk);
      check("mid_rst_psel_penable", {apb_psel, apb_penable}, 0);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_cmd_ready", cmd_ready, 0);
      p_rst = 1'b0;
      void'(exp_q.pop_front());
      rsp_seen  = 0;
      psel_seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge p_clk);
         if (rsp_valid) rsp_seen++;
         if (apb_psel) psel_seen++;
      end
      check("mid_rst_no_rsp", rsp_seen, 0);
      check("mid_rst_no_psel", psel_seen, 0);
      check("mid_rst_ready_back", cmd_ready, 1);

      run_vec(vecs[0], 9);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master
Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, APB data width; strobe width = APB_DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, ACCESS-phase wait limit; 0 disables the timeout.
REQ-004 SHALL have port p_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port p_rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 SHALL have port cmd_addr  input  APB_ADDR_WIDTH  byte address.
REQ-009 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have port cmd_wdata  input  APB_DATA_WIDTH  write data.
REQ-011 SHALL have port cmd_strb  input  APB_DATA_WIDTH/8  write byte strobes.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-014 SHALL have port rsp_rdata  output  APB_DATA_WIDTH  read data; 0 for writes and errors.
REQ-015 SHALL have port rsp_slverr  output  1  slave error, timeout or misalignment.
REQ-016 SHALL have port apb_paddr  output  APB_ADDR_WIDTH  APB address.
REQ-017 SHALL have port apb_pprot  output  apb_pkg::prot_t  constant 3'b000.
REQ-018 SHALL have port apb_psel  output  1  APB select.
REQ-019 SHALL have port apb_penable  output  1  APB enable.
REQ-020 SHALL have port apb_pwrite  output  1  APB direction.
REQ-021 SHALL have port apb_pwdata  output  APB_DATA_WIDTH  APB write data.
REQ-022 SHALL have port apb_pstrb  output  APB_DATA_WIDTH/8  APB strobes.
REQ-023 SHALL have ports apb_pready (input, 1), apb_prdata (input, APB_DATA_WIDTH) and apb_pslverr (input, 1), the slave completion signals.
Function
REQ-024 SHALL implement FSM IDLE, SETUP, ACCESS, RESP; all outputs registered or decoded only from state/registers.
REQ-025 SHALL drive cmd_ready=1 only in IDLE; on accept it SHALL capture addr/write/wdata/strb and go to SETUP, or to RESP if cmd_addr[1:0]!=0.
REQ-026 Misaligned command SHALL produce rsp_slverr=1, rsp_rdata=0, with no psel assertion.
REQ-027 SETUP SHALL last exactly 1 cycle with psel=1, penable=0, then go to ACCESS.
REQ-028 ACCESS SHALL hold psel=1, penable=1; paddr/pwrite/pwdata/pstrb SHALL be stable from SETUP through the end of ACCESS.
REQ-029 Reads SHALL drive pstrb=0 and pwdata=0.
REQ-030 On pready=1 in ACCESS: capture prdata (reads only) and pslverr, go to RESP; psel/penable SHALL be 0 next cycle.
REQ-031 A wait counter SHALL clear on ACCESS entry and increment per ACCESS cycle with pready=0; on the cycle it equals TIMEOUT_CYCLES-1 with pready=0, abort to RESP with slverr=1, rdata=0.
REQ-032 pready=1 in the timeout cycle SHALL complete normally (pready wins).
REQ-033 RESP SHALL hold rsp_valid=1 and stable rsp_* until rsp_ready=1, then go to IDLE.
REQ-034 Latency: accept at cycle T -> psel at T+1, penable at T+2, rsp_valid at T+3 for zero-wait slave; minimum 4 cycles per transfer.
Reset
REQ-035 p_rst=1 SHALL force IDLE at the next edge, including mid-transfer; pending response is discarded.
REQ-036 Reset values: cmd_ready=0 during reset; rsp_valid, psel, penable, pwrite, paddr, pwdata, pstrb, rsp_rdata, rsp_slverr, counter all 0.
Structure
REQ-037 Package apb_master_pkg SHALL hold the state enum typedef and the alignment/timeout constants; apb_pkg::prot_t is reused.
REQ-038 Timeout counter SHALL be sub-module apb_master_tmo (clear, enable, limit in; expire out).
Verification
REQ-039 Zero-wait write to 0x0013_0004, data 0x0003_3333, strb 0xF -> psel T+1, penable T+2, rsp_valid T+3, slverr=0.
REQ-040 Read 0x0013_0000 with pready after 3 wait cycles, prdata 0xA5A5_1234 -> rsp_rdata=0xA5A5_1234, rsp_valid at T+6.
REQ-041 Read with pready never high, TIMEOUT_CYCLES=8 -> psel drops after 8 ACCESS cycles, slverr=1, rdata=0.
REQ-042 Command to 0x0013_0002 -> no psel, rsp_valid T+1, slverr=1.
REQ-043 rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0 throughout, next command accepted only after handshake.
REQ-044 p_rst pulsed during ACCESS -> psel=penable=rsp_valid=0 next edge, no response issued.
